collatz_arb: RTL
================

COLLATZ_ARB -- requirements
Module: collatz_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one collatz iterator.
REQ-002 SHALL have parameter CNT_W, default 16, width of the iteration count.
REQ-003 SHALL have parameter MAX_ITER, default 16'hFFFF, count at which a run is aborted as overflow.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester start request.
REQ-007 SHALL have port req_n  input  32*NREQ  start values, requester i in bits [32*i+31:32*i].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot acceptance pulse.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  result consumer ready.
REQ-011 SHALL have port resp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-012 SHALL have port resp_count  output  CNT_W  sequence length, including the start value and the final 1.
REQ-013 SHALL have port resp_ovf  output  1  run aborted at MAX_ITER.
REQ-014 SHALL have port cgo  output  1  one-cycle load pulse to the collatz iterator.
REQ-015 SHALL have port cn  output  32  start value to the iterator; registered.
REQ-016 SHALL have port cdone  input  1  iterator done (dout==1).

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, RUN, RESP.
REQ-018 IDLE: if any req_valid, SHALL grant round-robin starting at pointer rr; req_ready[g]=1 combinationally that cycle; cn<=req_n[g]; id<=g; next state LAUNCH.
REQ-019 After a grant to g, rr SHALL become (g+1) mod NREQ; with a single requester asserting, it SHALL be granted every round.
REQ-020 req_ready SHALL be 0 in all states other than IDLE; at most one bit SHALL be high.
REQ-021 LAUNCH: cgo=1 for exactly this cycle; count<=1; next state RUN; cdone SHALL be ignored in this state (stale).
REQ-022 RUN, cdone=1: result count and ovf=0 captured; next state RESP.
REQ-023 RUN, cdone=0 and count==MAX_ITER: count MAX_ITER and ovf=1 captured; next state RESP.
REQ-024 RUN, otherwise: count<=count+1.
REQ-025 RESP: resp_valid=1 with resp_id/resp_count/resp_ovf stable until resp_ready=1; on the resp_ready cycle, next state IDLE.
REQ-026 Latency: accept at cycle A -> cgo at A+1 -> resp_valid at A+count+2 (no overflow).
REQ-027 New requests SHALL NOT be granted in RESP; the earliest next grant is the cycle after the handshake.
REQ-028 Count SHALL never wrap; MAX_ITER SHALL be <= 2^CNT_W-1.
REQ-029 req_valid deasserted after grant SHALL NOT affect the run in progress.
REQ-030 n=0 (never reaches 1) SHALL terminate via overflow.

Reset
REQ-031 rst_n=0 at an edge SHALL force IDLE; rr=0; cgo=0; resp_valid=0; resp_ovf=0; resp_count=0; resp_id=0; cn=0; req_ready=0.
REQ-032 Reset mid-RUN or mid-RESP SHALL drop the pending result without emitting it; the first grant after reset SHALL go to the lowest-index valid requester.

Verification
REQ-033 Single req: req 0, n=3, resp_ready=1 -> cgo 1 cycle after accept; resp_count=8, ovf=0, id=0, resp_valid 10 cycles after accept.
REQ-034 n=1 -> resp_count=1; n=7 -> 17; n=27 -> 112.
REQ-035 All 4 requesters valid continuously with n=5,6,7,9 -> grant order 0,1,2,3,0; counts 6,9,17,20.
REQ-036 Backpressure: resp_ready held 0 for 5 cycles -> resp fields stable, no req_ready, no cgo; handshake -> IDLE next cycle.
REQ-037 MAX_ITER=100, n=0 -> resp_ovf=1, resp_count=100.
REQ-038 rst_n=0 during RUN for n=27 -> no resp_valid; after release, req 2 and req 3 valid -> req 2 granted first.

Source files
------------

// File: rtl/collatz_arb.sv
// Round-robin arbiter that shares one external collatz iterator among NREQ requesters.
// Grants one start value at a time, counts the sequence length and returns it with an id.
module collatz_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [32*NREQ-1:0]       req_n,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [CNT_W-1:0]         resp_count,
  output logic                     resp_ovf,
  output logic                     cgo,
  output logic [31:0]              cn,
  input  logic                     cdone
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_ITER);
  localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_q, rr_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [31:0]      cn_q, cn_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;

  logic             grant_any;
  logic [IdW-1:0]   grant_id;
  logic [IdW-1:0]   scan_id;
  int unsigned      scan_idx;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      scan_idx = (32'(rr_q) + off) % NREQ;
      scan_id  = IdW'(scan_idx);
      if (!grant_any && req_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    cn_d        = cn_q;
    count_d     = count_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    req_ready   = '0;
    cgo         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no acceptance is signalled while reset is held.
        if (grant_any && rst_n) begin
          req_ready[grant_id] = 1'b1;
          cn_d                = req_n[32*32'(grant_id) +: 32];
          id_d                = grant_id;
          rr_d                = (grant_id == LastId) ? '0 : grant_id + 1'b1;
          state_d             = StLaunch;
        end
      end
      StLaunch: begin
        cgo     = 1'b1;
        count_d = CNT_W'(1);
        state_d = StRun;
      end
      StRun: begin
        if (cdone) begin
          res_count_d = count_q;
          res_ovf_d   = 1'b0;
          state_d     = StResp;
        end else if (count_q == MaxCnt) begin
          res_count_d = MaxCnt;
          res_ovf_d   = 1'b1;
          state_d     = StResp;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      id_q        <= '0;
      cn_q        <= '0;
      count_q     <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      cn_q        <= cn_d;
      count_q     <= count_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_id    = id_q;
  assign resp_count = res_count_q;
  assign resp_ovf   = res_ovf_q;
  assign cn         = cn_q;

endmodule
